// File: rtl/axi_wr_data_fifo.sv
// FWFT write-data FIFO feeding the AXI burst master: block RAM storage with a
// registered read port that doubles as the output register holding the head word.
module axi_wr_data_fifo #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_BITS    = 9,
  parameter int AEMPTY_LEVEL = 4,
  parameter int AFULL_LEVEL  = 508
) (
  input  logic                  mem_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  afull,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  aempty,
  output logic [ADDR_BITS:0]    level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_LVL  = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_LVL  = (ADDR_BITS + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_BITS:0] AEMPTY_LVL = (ADDR_BITS + 1)'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [ADDR_BITS-1:0]  rd_ptr;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic [ADDR_BITS:0]    avail;
  logic [ADDR_BITS:0]    level_next;

  // avail counts words already in RAM before this edge's write; the head is only
  // readable from those, which gives the one-cycle write-to-read latency.
  always_comb begin
    push       = wr_en && !full;
    pop        = rd_en && !empty;
    avail      = pop ? level - (ADDR_BITS + 1)'(1) : level;
    level_next = push ? avail + (ADDR_BITS + 1)'(1) : avail;
    rd_addr    = pop ? rd_ptr + ADDR_BITS'(1) : rd_ptr;
    load       = (avail != '0) && (pop || empty);
  end

  always_ff @(posedge mem_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (load) begin
      rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      empty     <= 1'b1;
      aempty    <= 1'b1;
      full      <= 1'b0;
      afull     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_BITS'(1);
      end
      rd_ptr    <= rd_addr;
      level     <= level_next;
      empty     <= (avail == '0);
      aempty    <= (level_next <= AEMPTY_LVL);
      full      <= (level_next == DEPTH_LVL);
      afull     <= (level_next >= AFULL_LVL);
      overflow  <= overflow | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
  end

endmodule

// File: tb/tb_axi_wr_data_fifo.sv
// Scoreboard bench for axi_wr_data_fifo: a queue of pushed words plus a small
// level/flag model, checked after every clock edge.
module tb_axi_wr_data_fifo;

  localparam int DW    = 64;
  localparam int AB    = 9;
  localparam int DEPTH = 512;

  logic          mem_clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          afull;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          aempty;
  logic [AB:0]   level;
  logic          overflow;
  logic          underflow;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] sb[$];
  int            m_level;
  bit            m_empty;
  bit            m_ovf;
  bit            m_unf;
  logic [DW-1:0] m_last;
  int            word_id;

  axi_wr_data_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_BITS(AB),
    .AEMPTY_LEVEL(4),
    .AFULL_LEVEL(508)
  ) dut (
    .mem_clk(mem_clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .afull(afull),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .aempty(aempty),
    .level(level),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("level", 64'(level), 64'(m_level));
    checkOutput("empty", 64'(empty), 64'(m_empty));
    checkOutput("full", 64'(full), 64'(m_level == DEPTH));
    checkOutput("afull", 64'(afull), 64'(m_level >= 508));
    checkOutput("aempty", 64'(aempty), 64'(m_level <= 4));
    checkOutput("overflow", 64'(overflow), 64'(m_ovf));
    checkOutput("underflow", 64'(underflow), 64'(m_unf));
    if (!m_empty) checkOutput("rd_data", rd_data, sb[0]);
    else          checkOutput("rd_hold", rd_data, m_last);
  endtask

  // One clock: drive inputs, advance the model with the pre-edge flags, check after the edge.
  task automatic applyStimulus(input bit wr, input logic [DW-1:0] d, input bit rd);
    bit push_ok;
    bit pop_ok;
    int avail;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    push_ok = wr && (m_level != DEPTH);
    pop_ok  = rd && !m_empty;
    if (wr && m_level == DEPTH) m_ovf = 1'b1;
    if (rd && m_empty) m_unf = 1'b1;
    if (pop_ok) void'(sb.pop_front());
    avail = m_level - int'(pop_ok);
    if (push_ok) sb.push_back(d);
    m_level = avail + int'(push_ok);
    m_empty = (avail == 0);
    if (!m_empty) m_last = sb[0];
    @(posedge mem_clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    checkAll();
  endtask

  task automatic doReset(input int cycles);
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (cycles) @(posedge mem_clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_level = 0;
    m_empty = 1'b1;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_last  = '0;
    checkAll();
  endtask

  function automatic logic [DW-1:0] nextWord();
    word_id++;
    return {32'hC0DE_0000, 32'(word_id)};
  endfunction

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    word_id = 0;
    doReset(2);

    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 64'(i), 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);

    // Fill to the brim, then overflow and a pop-while-full
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, nextWord(), 1'b0);
    applyStimulus(1'b1, 64'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 64'hBAD0_BAD0, 1'b1);

    while (m_level > 100) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 2000; i++) applyStimulus(1'b1, nextWord(), 1'b1);

    while (m_level > 0) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 64'hAA, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 64'h11, 1'b1);
    applyStimulus(1'b1, 64'h22, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);

    // Reset with a partly full FIFO; stale RAM must not reappear
    while (m_level < 300) applyStimulus(1'b1, nextWord(), 1'b0);
    doReset(1);
    applyStimulus(1'b1, 64'h55, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 64'h66, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
